// File: rtl/lsq_coef_eval_if.sv
// Handshake and data bundle for the regression coefficient / continuation stage.
interface lsq_coef_eval_if #(
    parameter int unsigned X_W    = 16,
    parameter int unsigned COEF_W = 32
);
    logic                     inv_valid;
    logic signed [31:0]       inv0;
    logic signed [19:0]       inv1;
    logic signed [20:0]       inv2;
    logic                     xty_valid;
    logic [32:0]              sy;
    logic [32:0]              sxy;
    logic                     x_valid;
    logic [X_W-1:0]           x;
    logic                     x_ready;
    logic                     coef_valid;
    logic signed [COEF_W-1:0] beta0;
    logic signed [COEF_W-1:0] beta1;
    logic                     cont_valid;
    logic signed [COEF_W-1:0] cont;
    logic                     busy;
    logic                     done;

    modport master (
        output inv_valid, inv0, inv1, inv2, xty_valid, sy, sxy, x_valid, x,
        input  x_ready, coef_valid, beta0, beta1, cont_valid, cont, busy, done
    );

    modport slave (
        input  inv_valid, inv0, inv1, inv2, xty_valid, sy, sxy, x_valid, x,
        output x_ready, coef_valid, beta0, beta1, cont_valid, cont, busy, done
    );
endinterface

// File: rtl/lsq_coef_eval.sv
// Least-squares final stage: beta = inv * [sy; sxy] on one shared multiplier,
// then per-path continuation value cont = beta0 + beta1 * x.
module lsq_coef_eval #(
    parameter int unsigned N        = 256,
    parameter int unsigned X_W      = 16,
    parameter int unsigned X_FRAC   = 4,
    parameter int unsigned B0_SHIFT = 10,
    parameter int unsigned B1_SHIFT = 6,
    parameter int unsigned COEF_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    lsq_coef_eval_if.slave     bus
);
    localparam int unsigned PROD_W = 66;
    localparam int unsigned ACC_W  = 67;
    localparam int unsigned XP_W   = COEF_W + X_W + 1;
    localparam int unsigned SUM_W  = XP_W - X_FRAC + 1;
    localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [COEF_W-1:0] COEF_MAX = {1'b0, {(COEF_W-1){1'b1}}};
    localparam logic signed [COEF_W-1:0] COEF_MIN = {1'b1, {(COEF_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_COEF, S_EVAL, S_DONE} state_t;

    state_t state_q, state_d;

    logic                     inv_valid_q, xty_valid_q;
    logic                     inv_have_q, xty_have_q;
    logic signed [31:0]       inv0_q;
    logic signed [19:0]       inv1_q;
    logic signed [20:0]       inv2_q;
    logic [32:0]              sy_q, sxy_q;
    logic [1:0]               mul_cnt_q;
    logic signed [ACC_W-1:0]  acc0_q, acc1_q;
    logic [CNT_W-1:0]         cnt_q;

    logic                     x_ready_q, x_ready_d;
    logic                     coef_valid_q, coef_valid_d;
    logic signed [COEF_W-1:0] beta0_q, beta0_d, beta1_q, beta1_d;
    logic                     cont_valid_q, cont_valid_d;
    logic signed [COEF_W-1:0] cont_q, cont_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic inv_rise, xty_rise, start, x_acc;
    logic signed [PROD_W-1:0] mul_a, mul_b, mul_p;
    logic signed [XP_W-1:0]   b1_ext, x_ext, xp;
    logic signed [SUM_W-1:0]  sum;

    assign inv_rise = bus.inv_valid & ~inv_valid_q;
    assign xty_rise = bus.xty_valid & ~xty_valid_q;
    assign start    = (state_q == S_IDLE) && (state_d == S_MUL);
    assign x_acc    = bus.x_valid & x_ready_q;

    // Clamp a wide signed value into the coefficient range.
    function automatic logic signed [COEF_W-1:0] sat_acc(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-COEF_W:0] top;
        top = v[ACC_W-1:COEF_W-1];
        if (&top || ~|top) return v[COEF_W-1:0];
        else if (v[ACC_W-1]) return COEF_MIN;
        else return COEF_MAX;
    endfunction

    function automatic logic signed [COEF_W-1:0] sat_sum(input logic signed [SUM_W-1:0] v);
        logic [SUM_W-COEF_W:0] top;
        top = v[SUM_W-1:COEF_W-1];
        if (&top || ~|top) return v[COEF_W-1:0];
        else if (v[SUM_W-1]) return COEF_MIN;
        else return COEF_MAX;
    endfunction

    // Shared multiplier operand select, one product per MUL cycle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (mul_cnt_q)
            2'd0: begin mul_a = PROD_W'(inv0_q); mul_b = PROD_W'(sy_q);  end
            2'd1: begin mul_a = PROD_W'(inv1_q); mul_b = PROD_W'(sxy_q); end
            2'd2: begin mul_a = PROD_W'(inv1_q); mul_b = PROD_W'(sy_q);  end
            default: begin mul_a = PROD_W'(inv2_q); mul_b = PROD_W'(sxy_q); end
        endcase
        mul_p = mul_a * mul_b;
    end

    // Continuation value datapath for the sample presented this cycle.
    always_comb begin
        b1_ext = XP_W'(beta1_q);
        x_ext  = XP_W'(bus.x);
        xp     = b1_ext * x_ext;
        sum    = SUM_W'(beta0_q) + SUM_W'(xp >>> X_FRAC);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if ((inv_have_q | inv_rise) & (xty_have_q | xty_rise)) state_d = S_MUL;
            S_MUL:   if (mul_cnt_q == 2'd3) state_d = S_COEF;
            S_COEF:  state_d = S_EVAL;
            S_EVAL:  if (x_acc && (cnt_q == CNT_W'(N - 1))) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values; every output is registered.
    always_comb begin
        x_ready_d    = (state_d == S_EVAL);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        coef_valid_d = 1'b0;
        beta0_d      = beta0_q;
        beta1_d      = beta1_q;
        cont_valid_d = 1'b0;
        cont_d       = cont_q;
        if (state_q == S_COEF) begin
            coef_valid_d = 1'b1;
            beta0_d      = sat_acc(acc0_q >>> B0_SHIFT);
            beta1_d      = sat_acc(acc1_q >>> B1_SHIFT);
        end
        if (x_acc) begin
            cont_valid_d = 1'b1;
            cont_d       = sat_sum(sum);
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            coef_valid_q <= 1'b0;
            beta0_q      <= '0;
            beta1_q      <= '0;
            cont_valid_q <= 1'b0;
            cont_q       <= '0;
        end else begin
            x_ready_q    <= x_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            coef_valid_q <= coef_valid_d;
            beta0_q      <= beta0_d;
            beta1_q      <= beta1_d;
            cont_valid_q <= cont_valid_d;
            cont_q       <= cont_d;
        end
    end

    // Edge capture of operands; the have flags are consumed when a regression
    // starts so edges arriving mid-regression queue up the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_valid_q <= 1'b0;
            xty_valid_q <= 1'b0;
            inv_have_q  <= 1'b0;
            xty_have_q  <= 1'b0;
            inv0_q      <= '0;
            inv1_q      <= '0;
            inv2_q      <= '0;
            sy_q        <= '0;
            sxy_q       <= '0;
        end else begin
            inv_valid_q <= bus.inv_valid;
            xty_valid_q <= bus.xty_valid;
            if (inv_rise) begin
                inv0_q <= bus.inv0;
                inv1_q <= bus.inv1;
                inv2_q <= bus.inv2;
            end
            if (xty_rise) begin
                sy_q  <= bus.sy;
                sxy_q <= bus.sxy;
            end
            if (start) begin
                inv_have_q <= 1'b0;
                xty_have_q <= 1'b0;
            end else begin
                if (inv_rise) inv_have_q <= 1'b1;
                if (xty_rise) xty_have_q <= 1'b1;
            end
        end
    end

    // Product accumulation and sample counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt_q <= '0;
            acc0_q    <= '0;
            acc1_q    <= '0;
            cnt_q     <= '0;
        end else begin
            if (state_q == S_MUL) begin
                mul_cnt_q <= mul_cnt_q + 2'd1;
                unique case (mul_cnt_q)
                    2'd0:    acc0_q <= ACC_W'(mul_p);
                    2'd1:    acc0_q <= acc0_q + ACC_W'(mul_p);
                    2'd2:    acc1_q <= ACC_W'(mul_p);
                    default: acc1_q <= acc1_q + ACC_W'(mul_p);
                endcase
            end else begin
                mul_cnt_q <= '0;
            end
            if (state_q == S_DONE) begin
                cnt_q <= '0;
            end else if (x_acc) begin
                cnt_q <= (cnt_q == CNT_W'(N - 1)) ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.x_ready    = x_ready_q;
    assign bus.coef_valid = coef_valid_q;
    assign bus.beta0      = beta0_q;
    assign bus.beta1      = beta1_q;
    assign bus.cont_valid = cont_valid_q;
    assign bus.cont       = cont_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_lsq_coef_eval.sv
// Directed bench for lsq_coef_eval: coefficient math, saturation, capture
// edge rules, full sample streaming and mid-run reset.
module tb_lsq_coef_eval;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lsq_coef_eval_if #(.X_W(16), .COEF_W(32)) bus ();

    lsq_coef_eval dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference continuation value: sat(b0 + floor(b1*x / 16)).
    function automatic logic signed [31:0] cont_model(input logic signed [31:0] b0,
                                                      input logic signed [31:0] b1,
                                                      input logic [15:0] xv);
        longint p, s;
        p = longint'(b1) * longint'({48'd0, xv});
        p = p >>> 4;
        s = longint'(b0) + p;
        if (s > 64'sd2147483647) return 32'sh7FFFFFFF;
        if (s < -64'sd2147483648) return 32'sh80000000;
        return 32'(s);
    endfunction

    task automatic load(input logic signed [31:0] i0, input logic signed [19:0] i1,
                        input logic signed [20:0] i2, input logic [32:0] s, input logic [32:0] sx);
        bus.inv0 = i0; bus.inv1 = i1; bus.inv2 = i2; bus.sy = s; bus.sxy = sx;
    endtask

    // Returns the number of negedges until coef_valid is seen (-1 if never).
    task automatic wait_coef(input bit drop, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1 && drop) begin
                bus.inv_valid = 1'b0;
                bus.xty_valid = 1'b0;
            end
            if (bus.coef_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Feed n samples, checking each cont one cycle after acceptance.
    task automatic stream(input int n, input bit gaps, input logic signed [31:0] b0,
                          input logic signed [31:0] b1, input bit is_end, input string tag);
        int sent = 0, got = 0, cyc = 0, pulses = 0;
        bit pending = 0, have_last = 0;
        logic signed [31:0] exp_c = '0, last_c = '0;
        logic e_done;
        logic [15:0] xv;
        while ((sent < n || pending) && cyc < 4 * n + 20) begin
            @(negedge clk);
            cyc++;
            if (bus.cont_valid === 1'b1) pulses++;
            if (pending) begin
                got++;
                checks++;
                if (bus.cont_valid !== 1'b1 || bus.cont !== exp_c) begin
                    errors++;
                    $display("FAIL %s_cont#%0d got valid=%b cont=%0d need valid=1 cont=%0d",
                             tag, got, bus.cont_valid, bus.cont, exp_c);
                end
                e_done = 1'(is_end && got == n);
                checks++;
                if (bus.done !== e_done) begin
                    errors++;
                    $display("FAIL %s_done#%0d got %b need %b", tag, got, bus.done, e_done);
                end
                last_c = exp_c;
                have_last = 1;
            end else if (have_last) begin
                checks++;
                if (bus.cont !== last_c) begin
                    errors++;
                    $display("FAIL %s_hold got %0d need %0d", tag, bus.cont, last_c);
                end
            end
            pending = 0;
            bus.x_valid = 1'b0;
            if (sent < n && (!gaps || $urandom_range(0, 2) != 0)) begin
                checks++;
                if (bus.x_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_x_ready got %b need 1", tag, bus.x_ready);
                end
                xv = 16'($urandom_range(0, 65535));
                bus.x = xv;
                bus.x_valid = 1'b1;
                exp_c = cont_model(b0, b1, xv);
                pending = 1;
                sent++;
            end
        end
        bus.x_valid = 1'b0;
        checks++;
        if (got != n || pulses != n) begin
            errors++;
            $display("FAIL %s_count got samples=%0d pulses=%0d need %0d", tag, got, pulses, n);
        end
        if (is_end) begin
            @(negedge clk);
            checks++;
            if ({bus.x_ready, bus.done, bus.busy, bus.cont_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL %s_after got rdy/done/busy/cv=%b need 0000", tag,
                         {bus.x_ready, bus.done, bus.busy, bus.cont_valid});
            end
        end
    endtask

    // Start a regression with same-cycle pulses and check latency and betas.
    task automatic regress(input string tag, input logic signed [31:0] e0, input logic signed [31:0] e1);
        int lat;
        @(negedge clk);
        bus.inv_valid = 1'b1;
        bus.xty_valid = 1'b1;
        wait_coef(1'b1, lat);
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL %s_latency got %0d need 6", tag, lat);
        end
        checks++;
        if (bus.beta0 !== e0 || bus.beta1 !== e1) begin
            errors++;
            $display("FAIL %s_beta got b0=%0d b1=%0d need b0=%0d b1=%0d", tag, bus.beta0, bus.beta1, e0, e1);
        end
    endtask

    task automatic test_reset();
        bus.inv_valid = 0; bus.xty_valid = 0; bus.x_valid = 0; bus.x = '0;
        load('0, '0, '0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.x_ready, bus.coef_valid, bus.beta0, bus.beta1, bus.cont_valid, bus.cont, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero b0=%0d b1=%0d cont=%0d busy=%b need all 0",
                     bus.beta0, bus.beta1, bus.cont, bus.busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load(32'sd1024, 20'sd0, 21'sd64, 33'd100, 33'd200);
        regress("t1", 32'sd100, 32'sd200);
        bus.x = 16'd16;
        bus.x_valid = 1'b1;
        @(negedge clk);
        bus.x_valid = 1'b0;
        checks++;
        if (bus.coef_valid !== 1'b0 || bus.cont_valid !== 1'b1 || bus.cont !== 32'sd300) begin
            errors++;
            $display("FAIL t1_first_cont got cv=%b valid=%b cont=%0d need cv=0 valid=1 cont=300",
                     bus.coef_valid, bus.cont_valid, bus.cont);
        end
        stream(255, 1'b1, 32'sd100, 32'sd200, 1'b1, "t1");
    endtask

    task automatic test_floor_and_reset_mid_eval();
        load(32'sd1024, -20'sd64, 21'sd64, 33'd100, 33'd200);
        regress("t2", 32'sd87, 32'sd100);
        stream(100, 1'b1, 32'sd87, 32'sd100, 1'b0, "t6pre");
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.x_ready, bus.coef_valid, bus.beta0, bus.beta1, bus.cont_valid, bus.cont, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL t6_async_reset got b0=%0d b1=%0d cont=%0d busy=%b rdy=%b need all 0",
                     bus.beta0, bus.beta1, bus.cont, bus.busy, bus.x_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load(32'sd1024, 20'sd0, -21'sd64, 33'd100, 33'd200);
        regress("t6", 32'sd100, -32'sd200);
        stream(256, 1'b1, 32'sd100, -32'sd200, 1'b1, "t6");
    endtask

    task automatic test_saturation();
        load(32'sh7FFFFFFF, 20'sd0, 21'sd0, 33'h0_FFFF_FFFF, 33'd0);
        regress("t3pos", 32'sh7FFFFFFF, 32'sd0);
        stream(256, 1'b1, 32'sh7FFFFFFF, 32'sd0, 1'b1, "t5");
        load(32'sh80000000, 20'sd0, 21'sd0, 33'h0_FFFF_FFFF, 33'd0);
        regress("t3neg", 32'sh80000000, 32'sd0);
        stream(256, 1'b0, 32'sh80000000, 32'sd0, 1'b1, "t3neg");
    endtask

    task automatic test_level_held();
        int lat, extra;
        load(32'sd1024, -20'sd64, 21'sd64, 33'd100, 33'd200);
        @(negedge clk);
        bus.xty_valid = 1'b1;
        @(negedge clk);
        bus.xty_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_xty_only_busy got %b need 0", bus.busy);
        end
        bus.inv_valid = 1'b1;
        wait_coef(1'b0, lat);
        checks++;
        if (lat != 6 || bus.beta0 !== 32'sd87 || bus.beta1 !== 32'sd100) begin
            errors++;
            $display("FAIL t4_coef got lat=%0d b0=%0d b1=%0d need lat=6 b0=87 b1=100",
                     lat, bus.beta0, bus.beta1);
        end
        stream(256, 1'b1, 32'sd87, 32'sd100, 1'b1, "t4");
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.coef_valid === 1'b1 || bus.busy !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL t4_no_recapture got %0d active cycles need 0", extra);
        end
        bus.inv_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor_and_reset_mid_eval();
        test_saturation();
        test_level_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
